cmac_msg_sequencer: RTL and testbench

Controller that runs one complete AES-CMAC computation on the CMAC core.
- Latches the key and message byte length on `start`.
- Issues the key load, then streams 128-bit message words into the core one block at a time.
- Pads the final partial block and drives last-block signalling.
- Returns the 128-bit tag.
- Sits between the host/stream interface and the CMAC core; it is the only driver of the core's load and control inputs.

---
 rtl/cmac_msg_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_cmac_msg_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmac_msg_sequencer.sv
// Sequencer for one AES-CMAC run: loads the key, streams padded 128-bit blocks
// into the CMAC core with last-block signalling, and returns the tag.
module cmac_msg_sequencer #(
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             CLK,
  input  logic             Rst_n,
  input  logic             start,
  input  logic [127:0]     key,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [127:0]     s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             core_ld_key,
  output logic             core_ld_block,
  output logic             core_last,
  output logic [7:0]       core_last_len,
  output logic [127:0]     core_key,
  output logic [127:0]     core_text,
  input  logic             core_done,
  input  logic [127:0]     core_text_out,
  output logic [127:0]     tag,
  output logic             tag_valid,
  output logic             busy,
  output logic             err
);

  localparam int unsigned CNT_W = LEN_W - 4;
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_KEY_LD   = 3'd1;
  localparam logic [2:0] S_KEY_WAIT = 3'd2;
  localparam logic [2:0] S_FETCH    = 3'd3;
  localparam logic [2:0] S_BLK_LD   = 3'd4;
  localparam logic [2:0] S_BLK_WAIT = 3'd5;

  logic [2:0]       r_state,      w_state_nxt;
  logic [CNT_W-1:0] r_blk_cnt,    w_blk_cnt_nxt;
  logic [TMO_W-1:0] r_tmo,        w_tmo_nxt;
  logic [127:0]     r_key,        w_key_nxt;
  logic             r_len_zero,   w_len_zero_nxt;
  logic [CNT_W-1:0] r_last_idx,   w_last_idx_nxt;
  logic [4:0]       r_last_bytes, w_last_bytes_nxt;
  logic [127:0]     r_text,       w_text_nxt;
  logic             r_last,       w_last_nxt;
  logic [127:0]     r_tag,        w_tag_nxt;
  logic             r_tag_valid,  w_tag_valid_nxt;
  logic             r_err,        w_err_nxt;
  logic             r_s_ready,    w_s_ready_nxt;
  logic             r_ld_key,     w_ld_key_nxt;
  logic             r_ld_block,   w_ld_block_nxt;
  logic             r_busy,       w_busy_nxt;

  logic [127:0]     w_fetch_word;
  logic             w_fetch_last;
  logic [127:0]     w_padded;

  // Final-block padding: keep bytes below R, byte R = 0x80, zero the rest
  always_comb begin
    w_fetch_word = r_len_zero ? 128'd0 : s_data;
    w_fetch_last = (r_blk_cnt == r_last_idx);
    w_padded     = w_fetch_word;
    if (w_fetch_last) begin
      for (int b = 0; b < 16; b++) begin
        if (b == int'(r_last_bytes))
          w_padded[127-8*b -: 8] = 8'h80;
        else if (b > int'(r_last_bytes))
          w_padded[127-8*b -: 8] = 8'h00;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt      = r_state;
    w_blk_cnt_nxt    = r_blk_cnt;
    w_tmo_nxt        = r_tmo;
    w_key_nxt        = r_key;
    w_len_zero_nxt   = r_len_zero;
    w_last_idx_nxt   = r_last_idx;
    w_last_bytes_nxt = r_last_bytes;
    w_text_nxt       = r_text;
    w_last_nxt       = r_last;
    w_tag_nxt        = r_tag;
    w_tag_valid_nxt  = 1'b0;
    w_err_nxt        = r_err;
    w_s_ready_nxt    = 1'b0;
    w_ld_key_nxt     = 1'b0;
    w_ld_block_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_key_nxt        = key;
          w_len_zero_nxt   = (msg_len == '0);
          w_last_idx_nxt   = (msg_len == '0) ? '0 : CNT_W'((msg_len - LEN_W'(1)) >> 4);
          w_last_bytes_nxt = (msg_len == '0)     ? 5'd0  :
                             (msg_len[3:0] == '0) ? 5'd16 : {1'b0, msg_len[3:0]};
          w_err_nxt        = 1'b0;
          w_blk_cnt_nxt    = '0;
          w_tmo_nxt        = '0;
          w_ld_key_nxt     = 1'b1;
          w_state_nxt      = S_KEY_LD;
        end
      end
      S_KEY_LD: begin
        w_tmo_nxt   = '0;
        w_state_nxt = S_KEY_WAIT;
      end
      S_KEY_WAIT: begin
        if (core_done) begin
          w_s_ready_nxt = !r_len_zero;
          w_state_nxt   = S_FETCH;
        end else if (r_tmo == TMO_MAX) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      S_FETCH: begin
        // Empty message takes an internal zero word without a handshake
        if (r_len_zero || (s_valid && r_s_ready)) begin
          w_text_nxt     = w_padded;
          w_last_nxt     = w_fetch_last;
          w_ld_block_nxt = 1'b1;
          w_state_nxt    = S_BLK_LD;
        end else begin
          w_s_ready_nxt = 1'b1;
        end
      end
      S_BLK_LD: begin
        w_tmo_nxt   = '0;
        w_state_nxt = S_BLK_WAIT;
      end
      S_BLK_WAIT: begin
        if (core_done) begin
          if (r_last) begin
            w_tag_nxt       = core_text_out;
            w_tag_valid_nxt = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            w_blk_cnt_nxt = r_blk_cnt + CNT_W'(1);
            w_s_ready_nxt = 1'b1;
            w_state_nxt   = S_FETCH;
          end
        end else if (r_tmo == TMO_MAX) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + TMO_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state      <= S_IDLE;
      r_blk_cnt    <= '0;
      r_tmo        <= '0;
      r_key        <= '0;
      r_len_zero   <= 1'b0;
      r_last_idx   <= '0;
      r_last_bytes <= '0;
      r_text       <= '0;
      r_last       <= 1'b0;
      r_tag        <= '0;
      r_tag_valid  <= 1'b0;
      r_err        <= 1'b0;
      r_s_ready    <= 1'b0;
      r_ld_key     <= 1'b0;
      r_ld_block   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_blk_cnt    <= w_blk_cnt_nxt;
      r_tmo        <= w_tmo_nxt;
      r_key        <= w_key_nxt;
      r_len_zero   <= w_len_zero_nxt;
      r_last_idx   <= w_last_idx_nxt;
      r_last_bytes <= w_last_bytes_nxt;
      r_text       <= w_text_nxt;
      r_last       <= w_last_nxt;
      r_tag        <= w_tag_nxt;
      r_tag_valid  <= w_tag_valid_nxt;
      r_err        <= w_err_nxt;
      r_s_ready    <= w_s_ready_nxt;
      r_ld_key     <= w_ld_key_nxt;
      r_ld_block   <= w_ld_block_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign s_ready       = r_s_ready;
  assign core_ld_key   = r_ld_key;
  assign core_ld_block = r_ld_block;
  assign core_last     = r_last;
  assign core_last_len = {r_last_bytes, 3'b000};
  assign core_key      = r_key;
  assign core_text     = r_text;
  assign tag           = r_tag;
  assign tag_valid     = r_tag_valid;
  assign busy          = r_busy;
  assign err           = r_err;

endmodule

// File: tb/tb_cmac_msg_sequencer.sv
// Scoreboard bench for cmac_msg_sequencer with a behavioural stand-in for the
// CMAC core; expected blocks and tags come from a byte-level message model.
module tb_cmac_msg_sequencer;

  localparam int unsigned LEN_W   = 16;
  localparam int unsigned TIMEOUT = 255;

  logic             CLK = 1'b0;
  logic             Rst_n;
  logic             start;
  logic [127:0]     key;
  logic [LEN_W-1:0] msg_len;
  logic [127:0]     s_data;
  logic             s_valid;
  logic             s_ready;
  logic             core_ld_key;
  logic             core_ld_block;
  logic             core_last;
  logic [7:0]       core_last_len;
  logic [127:0]     core_key;
  logic [127:0]     core_text;
  logic             core_done;
  logic [127:0]     core_text_out;
  logic [127:0]     tag;
  logic             tag_valid;
  logic             busy;
  logic             err;

  cmac_msg_sequencer #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .Rst_n(Rst_n), .start(start), .key(key), .msg_len(msg_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .core_ld_key(core_ld_key), .core_ld_block(core_ld_block),
    .core_last(core_last), .core_last_len(core_last_len),
    .core_key(core_key), .core_text(core_text),
    .core_done(core_done), .core_text_out(core_text_out),
    .tag(tag), .tag_valid(tag_valid), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [127:0] text;
    logic         last;
    logic [7:0]   last_len;
  } blk_t;

  blk_t         blk_q[$];
  logic [127:0] tag_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           hs_cnt  = 0;
  int           sr_cnt  = 0;
  bit           hold_off = 1'b0;
  logic [127:0] exp_tag_hold = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Stand-in core transform: any chaining function works as long as it sees text/last/len
  function automatic logic [127:0] core_step(input logic [127:0] acc, input logic [127:0] text,
                                             input logic last, input logic [7:0] ll);
    logic [127:0] r;
    r = {acc[126:0], acc[127]} ^ text;
    if (last) r = r ^ {120'd0, ll} ^ 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9696_6969;
    return r;
  endfunction

  // Core model: random latency, spurious done pulses while the sequencer is fetching
  int           c_cnt = 0;
  logic [127:0] c_acc = '0;
  always @(negedge CLK) begin
    if (!Rst_n) begin
      c_cnt     = 0;
      core_done = 1'b0;
    end else begin
      core_done = 1'b0;
      if (!hold_off && core_ld_key) begin
        c_acc = core_key;
        c_cnt = int'($urandom_range(1, 4));
      end else if (!hold_off && core_ld_block) begin
        c_acc = core_step(c_acc, core_text, core_last, core_last_len);
        c_cnt = int'($urandom_range(1, 4));
      end else if (c_cnt > 0) begin
        c_cnt--;
        if (c_cnt == 0) begin
          core_done     = 1'b1;
          core_text_out = c_acc;
        end
      end else if (s_ready && ($urandom_range(0, 3) == 0)) begin
        core_done     = 1'b1;
        core_text_out = rnd128();
      end
    end
  end

  // Monitor: pops expected blocks/tags whenever the DUT presents them
  always @(negedge CLK) begin
    if (Rst_n) begin
      if (s_ready) sr_cnt++;
      if (s_ready && s_valid) hs_cnt++;
      if (core_ld_block) begin
        if (blk_q.size() == 0) chk("unexpected_block", 128'(1), 128'(0));
        else begin
          blk_t e;
          e = blk_q.pop_front();
          chk("blk_text", core_text, e.text);
          chk("blk_last", 128'(core_last), 128'(e.last));
          if (e.last) chk("blk_last_len", 128'(core_last_len), 128'(e.last_len));
        end
      end
      if (tag_valid) begin
        if (tag_q.size() == 0) chk("unexpected_tag_valid", 128'(1), 128'(0));
        else begin
          logic [127:0] et;
          et = tag_q.pop_front();
          chk("tag", tag, et);
          exp_tag_hold = et;
        end
      end
    end
  end

  task automatic check_zero(input string pfx);
    chk({pfx, "_s_ready"},   128'(s_ready), 128'(0));
    chk({pfx, "_ld_key"},    128'(core_ld_key), 128'(0));
    chk({pfx, "_ld_block"},  128'(core_ld_block), 128'(0));
    chk({pfx, "_last"},      128'(core_last), 128'(0));
    chk({pfx, "_last_len"},  128'(core_last_len), 128'(0));
    chk({pfx, "_core_key"},  core_key, 128'(0));
    chk({pfx, "_core_text"}, core_text, 128'(0));
    chk({pfx, "_tag"},       tag, 128'(0));
    chk({pfx, "_tag_valid"}, 128'(tag_valid), 128'(0));
    chk({pfx, "_busy"},      128'(busy), 128'(0));
    chk({pfx, "_err"},       128'(err), 128'(0));
  endtask

  // One message: builds bytes, derives expected blocks/tag, drives start and the stream
  task automatic run_msg(input int len, input int gap_max, input bit junk,
                         input int abort_after, input bit poke_start);
    int           nblk, r, hs0, sr0, g;
    bit           ok;
    logic [127:0] k, acc, w, t;
    logic [127:0] words[$];
    logic [7:0]   bb[16];

    nblk = (len == 0) ? 1 : (len + 15) / 16;
    r    = len - 16 * (nblk - 1);
    k    = rnd128();
    acc  = k;
    for (int i = 0; i < nblk; i++) begin
      for (int j = 0; j < 16; j++)
        bb[j] = (16 * i + j < len) ? 8'($urandom()) : (junk ? 8'($urandom()) : 8'h00);
      for (int j = 0; j < 16; j++) w[127-8*j -: 8] = bb[j];
      words.push_back(w);
      if (i == nblk - 1 && r < 16) begin
        bb[r] = 8'h80;
        for (int j = r + 1; j < 16; j++) bb[j] = 8'h00;
      end
      for (int j = 0; j < 16; j++) t[127-8*j -: 8] = bb[j];
      blk_q.push_back('{text: t, last: (i == nblk - 1), last_len: 8'(8 * r)});
      acc = core_step(acc, t, (i == nblk - 1), 8'(8 * r));
    end
    tag_q.push_back(acc);
    hs0 = hs_cnt;
    sr0 = sr_cnt;

    @(posedge CLK); #1;
    key = k; msg_len = LEN_W'(len); start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0; key = rnd128(); msg_len = LEN_W'($urandom());
    @(negedge CLK);
    chk("busy_after_start", 128'(busy), 128'(1));
    chk("err_after_start", 128'(err), 128'(0));

    if (len > 0) begin
      for (int i = 0; i < nblk; i++) begin
        @(posedge CLK); #1;
        s_data = words[i]; s_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 500; c++) begin
          @(negedge CLK);
          if (s_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
          chk("handshake_timeout", 128'(0), 128'(1));
          s_valid = 1'b0;
          return;
        end
        @(posedge CLK); #1;
        s_valid = 1'b0; s_data = rnd128();
        if (poke_start && i == 0) begin
          start = 1'b1; key = rnd128(); msg_len = LEN_W'($urandom());
          @(posedge CLK); #1;
          start = 1'b0;
        end
        if (abort_after == i + 1) begin
          repeat (2) @(posedge CLK);
          #2 Rst_n = 1'b0;
          #1 check_zero("reset_mid");
          blk_q.delete();
          tag_q.delete();
          exp_tag_hold = '0;
          @(negedge CLK);
          Rst_n = 1'b1;
          return;
        end
        g = int'($urandom_range(0, gap_max));
        repeat (g) begin @(posedge CLK); #1; end
      end
    end

    ok = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge CLK);
      if (!busy) begin ok = 1'b1; break; end
    end
    #1;
    chk("run_completes", 128'(ok), 128'(1));
    chk("handshakes", 128'(hs_cnt - hs0), 128'((len == 0) ? 0 : nblk));
    if (len == 0) chk("no_s_ready_empty", 128'(sr_cnt - sr0), 128'(0));
    chk("tag_q_drained", 128'(tag_q.size()), 128'(0));
    chk("tag_held", tag, acc);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lens[6];
    lens[0] = 1; lens[1] = 15; lens[2] = 17; lens[3] = 31; lens[4] = 32; lens[5] = 33;
    Rst_n = 1'b0; start = 1'b0; key = '0; msg_len = '0;
    s_data = '0; s_valid = 1'b0;
    #12;
    check_zero("reset");
    @(negedge CLK);
    Rst_n = 1'b1;

    run_msg(0, 0, 1'b0, -1, 1'b0);
    run_msg(16, 2, 1'b0, -1, 1'b0);
    run_msg(40, 2, 1'b1, -1, 1'b0);
    run_msg(64, 5, 1'b0, -1, 1'b0);
    foreach (lens[i]) run_msg(lens[i], 2, 1'b1, -1, 1'b0);

    // Core never answers the key load
    hold_off = 1'b1;
    @(posedge CLK); #1;
    key = rnd128(); msg_len = LEN_W'(16); start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    chk("tmo_ld_key_seen", 128'(core_ld_key), 128'(1));
    n = 0;
    for (int c = 1; c <= int'(TIMEOUT) + 20; c++) begin
      @(negedge CLK);
      if (err) begin n = c; break; end
    end
    chk("tmo_window", 128'(n >= int'(TIMEOUT) && n <= int'(TIMEOUT) + 3), 128'(1));
    chk("tmo_err", 128'(err), 128'(1));
    chk("tmo_busy", 128'(busy), 128'(0));
    chk("tmo_tag_kept", tag, exp_tag_hold);
    hold_off = 1'b0;
    repeat (3) @(negedge CLK);
    run_msg(16, 1, 1'b0, -1, 1'b0);

    run_msg(48, 3, 1'b0, 2, 1'b0);
    run_msg(16, 2, 1'b0, -1, 1'b1);

    for (int i = 0; i < 20; i++)
      run_msg(int'($urandom_range(0, 100)), int'($urandom_range(0, 4)),
              1'($urandom_range(0, 1)), -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
